ulauc_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one mantissa ALU (add / shift-add multiply, start/finish handshake) between two requesters, e.g. the FP adder and FP multiplier control paths. It latches one requester's operands, issues a single start pulse to the ALU, and waits for a genuine finish. It then returns the result with a one-cycle acknowledge and hands priority to the other requester.

---
 rtl/ulauc_arbiter_if.sv | 30 +++
 rtl/ulauc_arbiter.sv | 121 ++++++++++++
 tb/tb_ulauc_arbiter.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ulauc_arbiter_if.sv
// Bundle of requester and mantissa-ALU signals shared by ulauc_arbiter and its environment.
// slave = arbiter side, master = requesters plus ALU.
interface ulauc_arbiter_if #(
  parameter int WIDTH = 23
) ();
  logic             req0, req1;
  logic             mul0, mul1;
  logic [WIDTH-1:0] a0, b0, a1, b1;
  logic             ack0, ack1;
  logic [WIDTH-1:0] res;
  logic             carry, err, busy;
  logic             alu_start, alu_mul;
  logic [WIDTH-1:0] alu_a, alu_b;
  logic [WIDTH-1:0] alu_dout;
  logic             alu_c_out, alu_finish;

  modport slave (
    input  req0, req1, mul0, mul1, a0, b0, a1, b1,
    input  alu_dout, alu_c_out, alu_finish,
    output ack0, ack1, res, carry, err, busy,
    output alu_start, alu_mul, alu_a, alu_b
  );

  modport master (
    output req0, req1, mul0, mul1, a0, b0, a1, b1,
    output alu_dout, alu_c_out, alu_finish,
    input  ack0, ack1, res, carry, err, busy,
    input  alu_start, alu_mul, alu_a, alu_b
  );
endinterface

// File: rtl/ulauc_arbiter.sv
// Round-robin arbiter/sequencer sharing one mantissa ALU between two requesters.
// Optional WAIT watchdog enabled by defining ULAUC_ARB_TIMEOUT_EN.
module ulauc_arbiter #(
  parameter int WIDTH          = 23,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic reset,
  ulauc_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, START, WAIT, DONE} state_t;

  state_t           state_q;
  logic             ptr_q, owner_q, arm_q;
  logic             ack0_q, ack1_q, start_q, mul_q, carry_q, err_q;
  logic [WIDTH-1:0] a_q, b_q, res_q;
  logic             grant_any_d, grant_sel_d, wdog_hit_d;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("ulauc_arbiter: TIMEOUT_CYCLES must be at least 1");
  end

  always_comb begin
    grant_any_d = bus.req0 | bus.req1;
    grant_sel_d = (bus.req0 && bus.req1) ? ptr_q : bus.req1;
  end

`ifdef ULAUC_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] wdog_q;

  assign wdog_hit_d = (state_q == WAIT) && (wdog_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wdog_q <= '0;
    end else if (state_q == START) begin
      wdog_q <= '0;
    end else if (state_q == WAIT && !wdog_hit_d) begin
      wdog_q <= wdog_q + CNT_W'(1);
    end
  end
`else
  assign wdog_hit_d = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= 1'b0;
      owner_q <= 1'b0;
      arm_q   <= 1'b0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      start_q <= 1'b0;
      mul_q   <= 1'b0;
      carry_q <= 1'b0;
      err_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
    end else begin
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      start_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (grant_any_d) begin
            owner_q <= grant_sel_d;
            mul_q   <= grant_sel_d ? bus.mul1 : bus.mul0;
            a_q     <= grant_sel_d ? bus.a1 : bus.a0;
            b_q     <= grant_sel_d ? bus.b1 : bus.b0;
            start_q <= 1'b1;
            state_q <= START;
          end
        end
        START: begin
          arm_q   <= 1'b0;
          state_q <= WAIT;
        end
        WAIT: begin
          // A finish left high by the previous op only counts after it has been seen low.
          if (!bus.alu_finish) arm_q <= 1'b1;
          if (arm_q && bus.alu_finish) begin
            res_q   <= bus.alu_dout;
            carry_q <= bus.alu_c_out;
            err_q   <= 1'b0;
            ack0_q  <= ~owner_q;
            ack1_q  <= owner_q;
            state_q <= DONE;
          end else if (wdog_hit_d) begin
            res_q   <= '0;
            carry_q <= 1'b0;
            err_q   <= 1'b1;
            ack0_q  <= ~owner_q;
            ack1_q  <= owner_q;
            state_q <= DONE;
          end
        end
        DONE: begin
          ptr_q   <= ~owner_q;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.ack0      = ack0_q;
  assign bus.ack1      = ack1_q;
  assign bus.res       = res_q;
  assign bus.carry     = carry_q;
  assign bus.err       = err_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.alu_start = start_q;
  assign bus.alu_mul   = mul_q;
  assign bus.alu_a     = a_q;
  assign bus.alu_b     = b_q;

endmodule

// File: tb/tb_ulauc_arbiter.sv
// Scoreboard bench for ulauc_arbiter: directed requests, behavioural ALU, queued expected acks.
module tb_ulauc_arbiter;
  localparam int W = 23;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ulauc_arbiter_if #(.WIDTH(W)) ifc ();
  ulauc_arbiter #(.WIDTH(W), .TIMEOUT_CYCLES(8)) dut (.clk(clk), .reset(reset), .bus(ifc));

  typedef struct packed {
    logic         port;
    logic [W-1:0] res;
    logic         carry;
    logic         err;
  } exp_t;

  exp_t sb[$];
  int   n_cmp  = 0;
  int   n_bad  = 0;
  int   alu_mode = 0;  // 0 normal, 1 stale finish, 2 never finishes
  int   alu_lat  = 2;
  int   pend0 = 0, pend1 = 0, rearm0 = 0;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, got, exp);
    end
  endtask

  task automatic expect_ack(input logic port, input logic [W-1:0] r, input logic c, input logic er);
    exp_t e;
    e.port = port; e.res = r; e.carry = c; e.err = er;
    sb.push_back(e);
  endtask

  task automatic drive(input logic port, input logic mul, input logic [W-1:0] a, input logic [W-1:0] b);
    if (!port) begin
      ifc.mul0 = mul; ifc.a0 = a; ifc.b0 = b; pend0++; ifc.req0 = 1'b1;
    end else begin
      ifc.mul1 = mul; ifc.a1 = a; ifc.b1 = b; pend1++; ifc.req1 = 1'b1;
    end
  endtask

  task automatic wait_done(input string nm, input int budget);
    int i;
    i = 0;
    while (i < budget && !(sb.size() == 0 && !ifc.busy && !ifc.req0 && !ifc.req1)) begin
      @(posedge clk); #1;
      i++;
    end
    check({nm, "_completed"}, 32'(i < budget), 32'd1);
  endtask

  // Requesters drop (or re-raise) their request on the cycle they are acknowledged.
  initial begin
    forever begin
      @(negedge clk);
      if (ifc.ack0) begin
        pend0--;
        ifc.req0 = (pend0 > 0);
      end
      if (ifc.ack1) begin
        pend1--;
        ifc.req1 = (pend1 > 0);
        if (rearm0 > 0) begin
          rearm0--;
          pend0++;
          ifc.req0 = 1'b1;
        end
      end
    end
  end

  // Scoreboard monitor.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (ifc.ack0 || ifc.ack1) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_ack: ack0=%0b ack1=%0b res=0x%0h err=%0b, required no ack",
                   ifc.ack0, ifc.ack1, ifc.res, ifc.err);
        end else begin
          e = sb.pop_front();
          check("ack_both_high", 32'(ifc.ack0 && ifc.ack1), 32'd0);
          check("ack_port", 32'(ifc.ack1), 32'(e.port));
          check("ack_res", 32'(ifc.res), 32'(e.res));
          check("ack_carry", 32'(ifc.carry), 32'(e.carry));
          check("ack_err", 32'(ifc.err), 32'(e.err));
        end
      end
    end
  end

  // Behavioural mantissa ALU.
  initial begin
    logic [W:0]     sum;
    logic [2*W-1:0] prod;
    ifc.alu_finish = 1'b0; ifc.alu_dout = '0; ifc.alu_c_out = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (ifc.alu_start) begin
        if (alu_mode == 1) begin
          ifc.alu_finish = 1'b1; ifc.alu_dout = 23'h000BAD; ifc.alu_c_out = 1'b1;
          repeat (3) @(posedge clk);
          #1 ifc.alu_finish = 1'b0;
          @(posedge clk);
          #1 ifc.alu_finish = 1'b1; ifc.alu_dout = 23'h000010; ifc.alu_c_out = 1'b0;
        end else begin
          ifc.alu_finish = 1'b0;
          if (alu_mode == 0) begin
            repeat (alu_lat) @(posedge clk);
            #1;
            if (ifc.alu_mul) begin
              prod = ifc.alu_a * ifc.alu_b;
              ifc.alu_dout = prod[W-1:0]; ifc.alu_c_out = 1'b0;
            end else begin
              sum = {1'b0, ifc.alu_a} + {1'b0, ifc.alu_b};
              ifc.alu_dout = sum[W-1:0]; ifc.alu_c_out = sum[W];
            end
            ifc.alu_finish = 1'b1;
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_time_limit: simulation did not finish, %0d compared", n_cmp);
    $fatal(1);
  end

  task automatic check_all_zero(input string nm);
    check({nm, "_ctrl"}, 32'({ifc.ack0, ifc.ack1, ifc.busy, ifc.alu_start, ifc.alu_mul, ifc.carry, ifc.err}), 32'd0);
    check({nm, "_res"}, 32'(ifc.res), 32'd0);
    check({nm, "_alu_a"}, 32'(ifc.alu_a), 32'd0);
    check({nm, "_alu_b"}, 32'(ifc.alu_b), 32'd0);
  endtask

  initial begin
    int i;
    reset = 1'b1;
    ifc.req0 = 1'b0; ifc.req1 = 1'b0; ifc.mul0 = 1'b0; ifc.mul1 = 1'b0;
    ifc.a0 = '0; ifc.b0 = '0; ifc.a1 = '0; ifc.b1 = '0;
    #1;
    check_all_zero("reset");
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;

    // Single add on port 0: one-cycle start, grant latency, ALU op select.
    expect_ack(1'b0, 23'h000008, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 23'h000003, 23'h000005);
    @(posedge clk); #1;
    check("t1_grant_latency", 32'(ifc.alu_start), 32'd1);
    check("t1_alu_mul", 32'(ifc.alu_mul), 32'd0);
    check("t1_alu_a", 32'(ifc.alu_a), 32'h3);
    @(posedge clk); #1;
    check("t1_start_width", 32'(ifc.alu_start), 32'd0);
    check("t1_busy", 32'(ifc.busy), 32'd1);
    wait_done("t1", 50);

    // Carry-out on port 1, then a multiply on port 0.
    expect_ack(1'b1, 23'h000000, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 23'h7FFFFF, 23'h000001);
    wait_done("t1_carry", 50);
    alu_lat = 3;
    expect_ack(1'b0, 23'd21, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 23'd3, 23'd7);
    @(posedge clk); #1;
    check("t1_alu_mul_sel", 32'(ifc.alu_mul), 32'd1);
    wait_done("t1_mul", 50);

    // Simultaneous requests after reset: port 0 first, twice over.
    alu_lat = 2;
    reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    expect_ack(1'b0, 23'd3, 1'b0, 1'b0);
    expect_ack(1'b1, 23'd30, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 23'd1, 23'd2);
    drive(1'b1, 1'b0, 23'd10, 23'd20);
    wait_done("t2_pair_a", 100);
    expect_ack(1'b0, 23'd8, 1'b0, 1'b0);
    expect_ack(1'b1, 23'h000123, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 23'd4, 23'd4);
    drive(1'b1, 1'b0, 23'h000100, 23'h000023);
    wait_done("t2_pair_b", 100);

    // req1 held through its first ack, req0 re-raised: grants alternate.
    expect_ack(1'b0, 23'd4, 1'b0, 1'b0);
    expect_ack(1'b1, 23'h000033, 1'b0, 1'b0);
    expect_ack(1'b0, 23'd4, 1'b0, 1'b0);
    expect_ack(1'b1, 23'h000033, 1'b0, 1'b0);
    rearm0 = 1;
    drive(1'b0, 1'b0, 23'd2, 23'd2);
    drive(1'b1, 1'b0, 23'h000011, 23'h000022);
    drive(1'b1, 1'b0, 23'h000011, 23'h000022);
    wait_done("t2_alternate", 200);

    // Stale finish level from the previous op must not complete the new one.
    alu_mode = 1;
    expect_ack(1'b0, 23'h000010, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 23'd8, 23'd8);
    wait_done("t3_stale", 50);
    alu_mode = 0;

    // Operand change after grant does not reach the ALU.
    alu_lat = 4;
    expect_ack(1'b0, 23'd3, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 23'h000001, 23'h000002);
    repeat (3) @(posedge clk);
    #1 ifc.a0 = 23'h7FFFFF;
    @(posedge clk); #1;
    check("t4_alu_a_in_wait", 32'(ifc.alu_a), 32'h1);
    wait_done("t4_latch", 50);
    check("t4_alu_a_after_ack", 32'(ifc.alu_a), 32'h1);

    // Reset in the middle of WAIT: everything clears, no ack for the abandoned op.
    alu_mode = 2;
    drive(1'b0, 1'b0, 23'd5, 23'd6);
    repeat (4) @(posedge clk);
    #1;
    check("t5_busy_before_reset", 32'(ifc.busy), 32'd1);
    reset = 1'b1;
    pend0 = 0; ifc.req0 = 1'b0;
    #1;
    check_all_zero("t5_reset");
    @(posedge clk); #1 reset = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("t5_idle_after_reset", 32'(ifc.busy), 32'd0);
    alu_mode = 0;
    alu_lat = 2;
    // Pointer was 1 before reset; after reset port 0 must win the tie.
    expect_ack(1'b0, 23'd11, 1'b0, 1'b0);
    expect_ack(1'b1, 23'd13, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 23'd5, 23'd6);
    drive(1'b1, 1'b0, 23'd6, 23'd7);
    wait_done("t5_ptr", 100);
    expect_ack(1'b1, 23'd11, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 23'd5, 23'd6);
    @(posedge clk); #1;
    check("t5_grant_latency", 32'(ifc.alu_start), 32'd1);
    wait_done("t5_lone", 50);

    // ALU that never finishes.
    alu_mode = 2;
`ifdef ULAUC_ARB_TIMEOUT_EN
    expect_ack(1'b0, 23'd0, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 23'd9, 23'd9);
    @(posedge clk); #1;
    check("t6_start", 32'(ifc.alu_start), 32'd1);
    i = 0;
    while (i < 30 && !ifc.ack0) begin
      @(posedge clk); #1;
      i++;
    end
    check("t6_timeout_latency", 32'(i), 32'd9);
    wait_done("t6_timeout", 50);
`else
    drive(1'b0, 1'b0, 23'd9, 23'd9);
    repeat (100) @(posedge clk);
    #1;
    check("t6_still_busy", 32'(ifc.busy), 32'd1);
    check("t6_err_low", 32'(ifc.err), 32'd0);
    check("t6_no_ack_pending", 32'(pend0), 32'd1);
    reset = 1'b1;
    pend0 = 0; ifc.req0 = 1'b0;
    @(posedge clk); #1 reset = 1'b0;
`endif

    // Normal op afterwards clears err.
    alu_mode = 0;
    expect_ack(1'b1, 23'd2, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 23'd1, 23'd1);
    wait_done("t7_recover", 50);

    check("sb_empty_at_end", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
